// File: rtl/fol_pkg.sv
// Shared defaults and helpers for the time-multiplexed first-order low-pass filter.
package fol_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int W_IN_DEF    = 16;
    localparam int W_OUT_DEF   = 32;
    localparam int N_SHIFT_DEF = 15;
    localparam int W_COEF_DEF  = 16;
    localparam int A_INIT_DEF  = 10000;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic logic ch_legal(input logic [31:0] ch, input int n_ch);
        return ch < 32'(n_ch);
    endfunction

    // Signed saturation of a wide intermediate to a w-bit two's complement range.
    function automatic logic signed [127:0] sat(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fol_mac_sat.sv
// One filter step: state + (coef * (target - state)) >>> N_SHIFT, saturated to W_OUT.
module fol_mac_sat
    import fol_pkg::*;
#(
    parameter int W_OUT   = W_OUT_DEF,
    parameter int W_COEF  = W_COEF_DEF,
    parameter int N_SHIFT = N_SHIFT_DEF
) (
    input  logic signed [W_OUT-1:0]  target,
    input  logic signed [W_OUT-1:0]  state,
    input  logic        [W_COEF-1:0] coef,
    output logic signed [W_OUT-1:0]  result
);

    localparam int WP = W_OUT + W_COEF + 2;

    logic signed [W_OUT:0]  diff;
    logic signed [WP-1:0]   prod;
    logic signed [WP-1:0]   step;
    logic signed [WP-1:0]   sum;

    // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
    always_comb begin
        diff   = (W_OUT + 1)'(target) - (W_OUT + 1)'(state);
        prod   = WP'($signed({1'b0, coef})) * WP'(diff);
        step   = prod >>> N_SHIFT;
        sum    = step + WP'(state);
        result = W_OUT'(sat(128'(sum), W_OUT));
    end

endmodule

// File: rtl/fol_filter_mc.sv
// Multi-channel first-order low-pass filter: one sample per cycle, result two cycles later,
// per-channel state and coefficient registers.
module fol_filter_mc
    import fol_pkg::*;
#(
    parameter int  N_CH    = N_CH_DEF,
    parameter int  W_IN    = W_IN_DEF,
    parameter int  W_OUT   = W_OUT_DEF,
    parameter int  N_SHIFT = N_SHIFT_DEF,
    parameter int  W_COEF  = W_COEF_DEF,
    parameter int  A_INIT  = A_INIT_DEF,
    localparam int CW      = ch_width(N_CH)
) (
    input  logic                    i_clkp,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic        [CW-1:0]    i_ch,
    input  logic signed [W_IN-1:0]  i_filter,
    input  logic                    i_bypass,
    input  logic                    i_coef_we,
    input  logic        [CW-1:0]    i_coef_ch,
    input  logic        [W_COEF-1:0] i_coef,
    output logic                    o_valid,
    output logic        [CW-1:0]    o_ch,
    output logic signed [W_OUT-1:0] o_filter,
    output logic                    o_err
);

    localparam int                F        = W_OUT - W_IN;
    localparam logic [63:0]       UNITY    = 64'd1 << N_SHIFT;
    localparam logic [63:0]       A_RST64  = (64'(A_INIT) < UNITY) ? 64'(A_INIT) : UNITY;
    localparam logic [W_COEF-1:0] COEF_MAX = W_COEF'(UNITY);
    localparam logic [W_COEF-1:0] COEF_RST = W_COEF'(A_RST64);

    logic signed [W_OUT-1:0]  state_q [N_CH];
    logic        [W_COEF-1:0] coef_q  [N_CH];

    logic                     sample_ok;
    logic                     wr_ok;
    logic        [W_COEF-1:0] wr_coef;
    logic        [W_COEF-1:0] eff_coef;

    logic                     s1_valid;
    logic                     s1_err;
    logic        [CW-1:0]     s1_ch;
    logic signed [W_IN-1:0]   s1_x;
    logic                     s1_byp;
    logic        [W_COEF-1:0] s1_coef;
    logic signed [W_OUT-1:0]  s1_xsh;
    logic signed [W_OUT-1:0]  s1_state;
    logic signed [W_OUT-1:0]  s1_mac;
    logic signed [W_OUT-1:0]  s1_next;

    logic                     s2_valid;
    logic                     s2_err;
    logic        [CW-1:0]     s2_ch;
    logic signed [W_OUT-1:0]  s2_res;

    // A same-cycle write to the sample's own channel takes effect for that sample.
    always_comb begin
        sample_ok = i_valid && ch_legal(32'(i_ch), N_CH);
        wr_ok     = i_coef_we && ch_legal(32'(i_coef_ch), N_CH);
        wr_coef   = (64'(i_coef) > UNITY) ? COEF_MAX : i_coef;
        eff_coef  = (wr_ok && (i_coef_ch == i_ch)) ? wr_coef : coef_q[i_ch];
    end

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            for (int c = 0; c < N_CH; c++) coef_q[c] <= COEF_RST;
        end else if (wr_ok) begin
            coef_q[i_coef_ch] <= wr_coef;
        end
    end

    // The whole update happens in one stage, so the next sample on a channel already sees
    // the written-back state and back-to-back samples need no extra bypass path.
    always_comb begin
        s1_xsh   = $signed({s1_x, {F{1'b0}}});
        s1_state = state_q[s1_ch];
        s1_next  = s1_byp ? s1_xsh : s1_mac;
    end

    fol_mac_sat #(
        .W_OUT   (W_OUT),
        .W_COEF  (W_COEF),
        .N_SHIFT (N_SHIFT)
    ) u_mac (
        .target (s1_xsh),
        .state  (s1_state),
        .coef   (s1_coef),
        .result (s1_mac)
    );

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            for (int c = 0; c < N_CH; c++) state_q[c] <= '0;
        end else if (s1_valid) begin
            state_q[s1_ch] <= s1_next;
        end
    end

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_ch    <= '0;
            s1_x     <= '0;
            s1_byp   <= 1'b0;
            s1_coef  <= '0;
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_ch    <= '0;
            s2_res   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_ch     <= '0;
            o_filter <= '0;
        end else begin
            s1_valid <= sample_ok;
            s1_err   <= i_valid && !sample_ok;
            if (sample_ok) begin
                s1_ch   <= i_ch;
                s1_x    <= i_filter;
                s1_byp  <= i_bypass;
                s1_coef <= eff_coef;
            end
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
            if (s1_valid) begin
                s2_ch  <= s1_ch;
                s2_res <= s1_next;
            end
            o_valid <= s2_valid;
            o_err   <= s2_err || (i_coef_we && !wr_ok);
            if (s2_valid) begin
                o_ch     <= s2_ch;
                o_filter <= s2_res;
            end
        end
    end

endmodule

// File: tb/tb_fol_filter_mc.sv
// Self-checking bench for fol_filter_mc with three channels so that i_ch = 3 is illegal.
module tb_fol_filter_mc;

    localparam int N_CH = 3;
    localparam int CW   = 2;

    logic               i_clkp    = 1'b0;
    logic               i_rstn    = 1'b0;
    logic               i_valid   = 1'b0;
    logic [CW-1:0]      i_ch      = '0;
    logic signed [15:0] i_filter  = '0;
    logic               i_bypass  = 1'b0;
    logic               i_coef_we = 1'b0;
    logic [CW-1:0]      i_coef_ch = '0;
    logic [15:0]        i_coef    = '0;
    logic               o_valid;
    logic [CW-1:0]      o_ch;
    logic signed [31:0] o_filter;
    logic               o_err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: per-channel state and latest coefficient, plus a two-deep result delay.
    longint m_s [N_CH];
    longint m_a [N_CH];
    bit     pv   [2];
    bit     perr [2];
    int     pch  [2];
    longint pval [2];

    logic               exp_valid;
    logic               exp_err;
    logic [CW-1:0]      exp_ch;
    logic signed [31:0] exp_filter;

    logic               obs_valid;
    logic               obs_err;
    logic [CW-1:0]      obs_ch;
    logic signed [31:0] obs_filter;
    longint             got [$];
    int                 n_err_seen;

    fol_filter_mc #(.N_CH(N_CH)) dut (
        .i_clkp    (i_clkp),
        .i_rstn    (i_rstn),
        .i_valid   (i_valid),
        .i_ch      (i_ch),
        .i_filter  (i_filter),
        .i_bypass  (i_bypass),
        .i_coef_we (i_coef_we),
        .i_coef_ch (i_coef_ch),
        .i_coef    (i_coef),
        .o_valid   (o_valid),
        .o_ch      (o_ch),
        .o_filter  (o_filter),
        .o_err     (o_err)
    );

    always #5 i_clkp = ~i_clkp;

    function automatic longint m_clamp(input longint c);
        return (c > 32768) ? 64'sd32768 : c;
    endfunction

    function automatic longint m_update(input longint s, input longint x, input longint a, input bit byp);
        longint t;
        longint n;
        t = x * 65536;
        if (byp) return t;
        n = s + ((a * (t - s)) >>> 15);
        if (n > 64'sd2147483647) n = 64'sd2147483647;
        if (n < -64'sd2147483648) n = -64'sd2147483648;
        return n;
    endfunction

    task automatic cycle(input bit v, input int ch, input int x, input bit byp,
                         input bit we, input int cch, input int coef, input bit rstn);
        longint a;
        i_valid   = v;
        i_ch      = CW'(ch);
        i_filter  = 16'(x);
        i_bypass  = byp;
        i_coef_we = we;
        i_coef_ch = CW'(cch);
        i_coef    = 16'(coef);
        i_rstn    = rstn;
        @(posedge i_clkp);
        if (!rstn) begin
            for (int c = 0; c < N_CH; c++) begin
                m_s[c] = 0;
                m_a[c] = 10000;
            end
            for (int k = 0; k < 2; k++) begin
                pv[k] = 0;
                perr[k] = 0;
            end
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            exp_ch     = '0;
            exp_filter = '0;
        end else begin
            exp_valid = pv[1];
            if (pv[1]) begin
                exp_ch     = CW'(pch[1]);
                exp_filter = 32'(pval[1]);
            end
            exp_err = perr[1] || (we && cch >= N_CH);
            pv[1] = pv[0]; perr[1] = perr[0]; pch[1] = pch[0]; pval[1] = pval[0];
            pv[0]   = v && (ch < N_CH);
            perr[0] = v && (ch >= N_CH);
            if (pv[0]) begin
                a = (we && cch == ch) ? m_clamp(coef) : m_a[ch];
                m_s[ch] = m_update(m_s[ch], x, a, byp);
                pch[0]  = ch;
                pval[0] = m_s[ch];
            end
            if (we && cch < N_CH) m_a[cch] = m_clamp(coef);
        end
        @(negedge i_clkp);
        obs_valid  = o_valid;
        obs_err    = o_err;
        obs_ch     = o_ch;
        obs_filter = o_filter;
        if (o_valid === 1'b1) got.push_back(longint'(o_filter));
        if (o_err === 1'b1) n_err_seen++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 123, 0, 1, 1, 500, 0);
        n_total++;
        if ({obs_valid, obs_err, obs_ch, obs_filter} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got v=%b e=%b ch=%0d y=%0d, want all zero",
                     obs_valid, obs_err, obs_ch, obs_filter);
        end
        idle(1);
    endtask

    task automatic test_step;
        longint want [3] = '{32768000, 49152000, 57344000};
        got.delete();
        cycle(1, 0, 1000, 0, 1, 0, 16384, 1);
        cycle(1, 0, 1000, 0, 0, 0, 0, 1);
        cycle(1, 0, 1000, 0, 0, 0, 0, 1);
        idle(2);
        n_total++;
        if (got.size() != 3) begin
            n_bad++;
            $display("[TB] FAIL step_count: got %0d outputs, want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== want[i]) begin
                n_bad++;
                $display("[TB] FAIL step_%0d: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_clamp;
        longint want [3] = '{-32768000, -32768000, 32768000};
        got.delete();
        cycle(0, 0, 0, 0, 1, 0, 32768, 1);
        cycle(1, 0, -500, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 40000, 1);
        cycle(1, 0, -500, 0, 0, 0, 0, 1);
        cycle(1, 0, 500, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== want[i]) begin
                n_bad++;
                $display("[TB] FAIL clamp_%0d: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        longint want [3] = '{32768000, 49152000, 57344000};
        got.delete();
        cycle(0, 0, 0, 0, 1, 1, 16384, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1000, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== want[i]) begin
                n_bad++;
                $display("[TB] FAIL fwd_%0d: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_coef_timing;
        longint want [3] = '{13107200, 19660800, 6553600};
        got.delete();
        cycle(1, 2, 200, 0, 1, 2, 32768, 1);
        cycle(0, 0, 0, 0, 1, 1, 0, 1);
        cycle(1, 2, 300, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 2, 5000, 1);
        cycle(0, 0, 0, 0, 1, 2, 32768, 1);
        cycle(1, 2, 100, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== want[i]) begin
                n_bad++;
                $display("[TB] FAIL coef_%0d: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_bypass_illegal;
        bit exp_pat [4] = '{0, 0, 1, 0};
        bit ev [4];
        bit vv [4];
        got.delete();
        cycle(1, 0, 7, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        cycle(1, 0, 1234, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== 64'sd458752) begin
                n_bad++;
                $display("[TB] FAIL bypass_%0d: got %0d, want 458752", i, (i < got.size()) ? got[i] : -1);
            end
        end
        cycle(1, 3, 55, 0, 0, 0, 0, 1);
        ev[0] = obs_err; vv[0] = obs_valid;
        for (int i = 1; i < 4; i++) begin
            idle(1);
            ev[i] = obs_err; vv[i] = obs_valid;
        end
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (ev[i] !== exp_pat[i] || vv[i] !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL illegal_sample_%0d: got err=%b valid=%b, want err=%b valid=0",
                         i, ev[i], vv[i], exp_pat[i]);
            end
        end
        cycle(0, 0, 0, 0, 1, 3, 1, 1);
        ev[0] = obs_err;
        idle(1);
        ev[1] = obs_err;
        n_total++;
        if (ev[0] !== 1'b1 || ev[1] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL illegal_coef: got err=%b,%b, want 1,0", ev[0], ev[1]);
        end
    endtask

    task automatic test_random(input int n_cyc, input int n_chan);
        for (int k = 0; k < n_cyc; k++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, n_chan - 1)),
                  int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, int'($urandom_range(0, n_chan - 1)),
                  int'($urandom_range(0, 40000)), 1'b1);
            n_total++;
            if (obs_valid !== exp_valid || obs_err !== exp_err ||
                obs_ch !== exp_ch || obs_filter !== exp_filter) begin
                n_bad++;
                $display("[TB] FAIL random_%0d: got v=%b e=%b ch=%0d y=%0d, want v=%b e=%b ch=%0d y=%0d",
                         k, obs_valid, obs_err, obs_ch, obs_filter,
                         exp_valid, exp_err, exp_ch, exp_filter);
            end
        end
    endtask

    task automatic test_reset_midstream;
        int seen;
        for (int k = 0; k < 6; k++) cycle(1, k % 3, 100 * k - 200, 0, 0, 0, 0, 1);
        got.delete();
        cycle(1, 0, 999, 0, 0, 0, 0, 0);
        seen = (obs_valid === 1'b1) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            idle(1);
            if (obs_valid === 1'b1) seen++;
        end
        n_total++;
        if (seen != 0) begin
            n_bad++;
            $display("[TB] FAIL reset_inflight: got %0d valid outputs, want 0", seen);
        end
        cycle(1, 0, 1000, 0, 0, 0, 0, 1);
        idle(2);
        n_total++;
        if (got.size() != 1 || got[0] !== 64'sd20000000) begin
            n_bad++;
            $display("[TB] FAIL reset_first: got %0d outputs first=%0d, want 1 output 20000000",
                     got.size(), (got.size() > 0) ? got[0] : -1);
        end
    endtask

    initial begin
        n_err_seen = 0;
        @(negedge i_clkp);
        test_reset();
        test_step();
        test_clamp();
        test_back_to_back();
        test_coef_timing();
        test_bypass_illegal();
        test_random(60, 2);
        test_random(300, 4);
        test_reset_midstream();
        test_random(100, 4);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fol_filter_mc.md
FOL_FILTER_MC -- requirements
Module: fol_filter_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of time-multiplexed channels (1..16).
REQ-002 SHALL have parameter W_IN, default 16: signed sample width.
REQ-003 SHALL have parameter W_OUT, default 32: signed state/output width; F = W_OUT-W_IN fractional bits (F >= 1).
REQ-004 SHALL have parameter N_SHIFT, default 15: coefficient fractional bits (unity = 2^N_SHIFT).
REQ-005 SHALL have parameter W_COEF, default 16: unsigned coefficient width.
REQ-006 SHALL have parameter A_INIT, default 10000: per-channel coefficient after reset.
REQ-007 SHALL have the following ports, with CW = max(1, clog2(N_CH)):
  i_clkp  in  1  sole clock, rising edge
  i_rstn  in  1  synchronous active-low reset
  i_valid  in  1  sample strobe
  i_ch  in  CW  sample channel
  i_filter  in  W_IN  signed sample
  i_bypass  in  1  pass-through mode, global
  i_coef_we  in  1  coefficient write strobe
  i_coef_ch  in  CW  coefficient target channel
  i_coef  in  W_COEF  unsigned coefficient
  o_valid  out  1  result strobe
  o_ch  out  CW  result channel
  o_filter  out  W_OUT  signed filtered result
  o_err  out  1  one-cycle pulse on an illegal channel

Function
REQ-008 SHALL be always ready: one sample accepted per cycle while i_valid=1, with no back-pressure.
REQ-009 SHALL compute per channel c: s_c <= sat(s_c + ((a_c * ((x <<< F) - s_c)) >>> N_SHIFT)), arithmetic shift, full-precision intermediate (W_OUT+1+W_COEF bits), saturated to W_OUT signed.
REQ-010 SHALL output o_filter equal to the updated s_c, with o_valid and o_ch asserted exactly 2 cycles after the accepting edge.
REQ-011 SHALL forward the in-flight result so that back-to-back or every-other-cycle samples on the same channel give results bit-identical to fully serialised processing.
REQ-012 SHALL clamp the effective coefficient to 2^N_SHIFT when i_coef exceeds it; the clamp is applied at write time.
REQ-013 SHALL hold coefficient writes in a per-channel shadow register, committed at the channel's next accepted sample; that sample and all later samples use the new value.
REQ-014 SHALL make a sample accepted in the same cycle as a coefficient write to its own channel use the new coefficient; if several writes to one channel occur between samples, the last write wins.
REQ-015 SHALL, when i_bypass=1, output x <<< F and load s_c with x <<< F, so that leaving bypass is bumpless; i_bypass is sampled with each sample.
REQ-016 SHALL drop a sample with i_ch >= N_CH: no state change, no o_valid, and o_err pulsed at the o_valid timing. A coefficient write to a channel >= N_CH SHALL be ignored and SHALL pulse o_err the next cycle.
REQ-017 SHALL hold o_filter and o_ch at their last values while o_valid=0.

Reset
REQ-018 SHALL, on i_rstn=0 at a rising edge, clear all s_c to 0, set all a_c and all shadow coefficients to min(A_INIT, 2^N_SHIFT), and flush the pipeline.
REQ-019 SHALL hold o_valid=0, o_err=0, o_ch=0 and o_filter=0 during reset and until the first result after reset.
REQ-020 SHALL produce no output for samples in flight when reset asserts mid-operation.

Structure
REQ-021 SHALL define the shared constants (defaults, CW function) and the sat() helper in the package fol_pkg.
REQ-022 SHALL instantiate the arithmetic stage (subtract, multiply, shift, add, saturate) as the sub-module fol_mac_sat, parameterised by W_OUT, W_COEF and N_SHIFT.
REQ-023 SHALL hold the channel state and coefficients in registers indexed by channel, not in block RAM.

Verification
REQ-024 SHALL cover step response: ch0, a=16384, x=1000 constant -> o_filter = 32768000, 49152000, 57344000 on the first 3 outputs.
REQ-025 SHALL cover pass-through and clamp: a=32768 and then a=40000, x=-500 -> first output -32768000 in both cases.
REQ-026 SHALL cover forwarding: ch1 receives x=1000 on 3 consecutive cycles with a=16384 -> same values as REQ-024; interleaving ch0/ch1 SHALL leave each channel's sequence independent.
REQ-027 SHALL cover coefficient timing: write a=32768 to ch2 in the same cycle as a ch2 sample x=200 -> output 13107200; a write to ch1 SHALL not affect ch2.
REQ-028 SHALL cover bypass and illegal channels: bypass with x=7 -> 458752, then after bypass with a=0 the output stays 458752; a sample on i_ch=N_CH -> o_err pulse and no o_valid.
REQ-029 SHALL cover reset mid-stream: assert i_rstn=0 for 1 cycle during streaming -> no o_valid for in-flight samples, and the next ch0 sample x=1000 with a=A_INIT gives 20000000.
